lfsr_gen: RTL

- Parametrised successor to the fixed 8/16/64-bit LFSRs: one register, any width, any tap mask.
- Supports Fibonacci or Galois form, several steps per clock, and a multi-cycle skip-ahead engine.
- Detects and recovers from all-zero (lock-up) seeds.
- Sits between the seed source and every downstream consumer of `shift_seed` (pattern/key generation).

---
 rtl/lfsr_gen_pkg.sv | 33 +++
 rtl/lfsr_gen_if.sv | 26 ++
 rtl/lfsr_gen_stepper.sv | 28 ++
 rtl/lfsr_gen.sv | 103 ++++++++++
 4 files changed

// File: rtl/lfsr_gen_pkg.sv
// Shared types, maximal-length tap constants and the single-step LFSR function
// used by every LFSR in the pattern/key generation path.
package lfsr_pkg;

    typedef enum logic {FIBONACCI = 1'b0, GALOIS = 1'b1} lfsr_mode_e;
    typedef enum logic {IDLE = 1'b0, SKIP = 1'b1} skip_state_e;

    localparam logic [7:0]  TAPS8  = 8'hB8;
    localparam logic [15:0] TAPS16 = 16'hB400;
    localparam logic [31:0] TAPS32 = 32'h8020_0003;
    localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

    // Operates on a 64-bit carrier; bits at and above 'width' are forced to zero.
    function automatic logic [63:0] lfsr_step1(input logic [63:0] state,
                                               input logic [63:0] taps,
                                               input lfsr_mode_e  mode,
                                               input int unsigned width);
        logic [63:0] mask;
        logic [63:0] poly;
        logic [63:0] next;
        logic        fb;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        poly = ((taps << 1) | 64'd1) & mask;
        fb   = ^(state & taps & mask);
        if (mode == FIBONACCI) begin
            next = ((state << 1) | {63'd0, fb}) & mask;
        end else begin
            next = ((state << 1) & mask) ^ (state[width-1] ? poly : 64'd0);
        end
        return next;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between a seed source (master) and the LFSR generator (slave).
interface lfsr_gen_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             en;
    logic             skip_start;
    logic [CNT_W-1:0] skip_count;
    logic             busy;
    logic             skip_done;
    logic             lockup;
    logic [WIDTH-1:0] shift_seed;
    logic             bit_out;

    modport master (
        output load, seed, en, skip_start, skip_count,
        input  busy, skip_done, lockup, shift_seed, bit_out
    );

    modport slave (
        input  load, seed, en, skip_start, skip_count,
        output busy, skip_done, lockup, shift_seed, bit_out
    );
endinterface

// File: rtl/lfsr_gen_stepper.sv
// Combinational chain of STEPS single LFSR steps; n_i selects how many are applied.
module lfsr_stepper
    import lfsr_pkg::*;
#(
    parameter int          WIDTH = 64,
    parameter logic [63:0] TAPS  = TAPS64,
    parameter lfsr_mode_e  MODE  = FIBONACCI,
    parameter int          STEPS = 1,
    parameter int          NW    = $clog2(STEPS + 1)
)(
    input  logic [WIDTH-1:0] state_i,
    input  logic [NW-1:0]    n_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] chain;

    // n_i == 0 (or out of range) passes the state through untouched.
    always_comb begin
        chain   = state_i;
        state_o = state_i;
        for (int k = 1; k <= STEPS; k++) begin
            chain = WIDTH'(lfsr_step1(64'(chain), TAPS, MODE, WIDTH));
            if (n_i == NW'(k)) state_o = chain;
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with multi-step advance, skip-ahead engine and zero-seed filtering.
module lfsr_gen #(
    parameter int               WIDTH        = 64,
    parameter logic [63:0]      TAPS         = 64'hD800_0000_0000_0000,
    parameter int               GALOIS       = 0,
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
    parameter int               CNT_W        = 32
)(
    input logic       clk,
    input logic       reset,
    lfsr_gen_if.slave bus
);
    import lfsr_pkg::*;

    localparam lfsr_mode_e MODE   = (GALOIS != 0) ? lfsr_pkg::GALOIS : lfsr_pkg::FIBONACCI;
    localparam int         NW     = $clog2(STEPS + 1);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_SKIP = SKIP;

    logic [WIDTH-1:0] shiftSeed_q, shiftSeed_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [0:0]       fsm_q, fsm_d;
    logic             skipDone_q, skipDone_d;
    logic             lockup_q, lockup_d;
    logic [NW-1:0]    nSteps;
    logic [WIDTH-1:0] advanced;

    lfsr_stepper #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE),
        .STEPS (STEPS),
        .NW    (NW)
    ) u_stepper (
        .state_i (shiftSeed_q),
        .n_i     (nSteps),
        .state_o (advanced)
    );

    always_comb begin
        shiftSeed_d = shiftSeed_q;
        remaining_d = remaining_q;
        fsm_d       = fsm_q;
        skipDone_d  = 1'b0;
        lockup_d    = lockup_q;
        nSteps      = '0;
        if (bus.load) begin
            // A zero seed would lock the register up, so it is replaced and flagged.
            shiftSeed_d = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
            lockup_d    = (bus.seed == '0);
            fsm_d       = S_IDLE;
            remaining_d = '0;
        end else if (fsm_q == S_IDLE) begin
            if (bus.skip_start) begin
                if (bus.skip_count == '0) begin
                    skipDone_d = 1'b1;
                end else begin
                    fsm_d       = S_SKIP;
                    remaining_d = bus.skip_count;
                end
            end else if (bus.en) begin
                nSteps      = NW'(STEPS);
                shiftSeed_d = advanced;
            end
        end else begin
            if (remaining_q <= CNT_W'(STEPS)) begin
                nSteps      = NW'(remaining_q);
                shiftSeed_d = advanced;
                remaining_d = '0;
                fsm_d       = S_IDLE;
                skipDone_d  = 1'b1;
            end else begin
                nSteps      = NW'(STEPS);
                shiftSeed_d = advanced;
                remaining_d = remaining_q - CNT_W'(STEPS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftSeed_q <= SEED_DEFAULT;
            remaining_q <= '0;
            fsm_q       <= S_IDLE;
            skipDone_q  <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            shiftSeed_q <= shiftSeed_d;
            remaining_q <= remaining_d;
            fsm_q       <= fsm_d;
            skipDone_q  <= skipDone_d;
            lockup_q    <= lockup_d;
        end
    end

    assign bus.busy       = (fsm_q == S_SKIP);
    assign bus.skip_done  = skipDone_q;
    assign bus.lockup     = lockup_q;
    assign bus.shift_seed = shiftSeed_q;
    assign bus.bit_out    = shiftSeed_q[WIDTH-1];

endmodule
